catch_object_multi: RTL and testbench

- Parametrised successor to the per-sprite catchable-object blocks (gold/stone) in the Gold Miner game.
- Tracks one catchable object shared by NUM_HOOKS claw hooks. It detects a hook-tail hit, arbitrates simultaneous hits, and pulls the object along the capturing hook's direction.
- Ends with a one-cycle score pulse when the hook returns, or a no-score destroy if that hook's dynamite is fired.
- Feeds the sprite mux (draw hit plus ROM address) and the score/hook controllers.

---
 rtl/catch_object_multi.sv | 182 ++++++++++++++++++
 tb/tb_catch_object_multi.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/catch_object_multi.sv
// catch_object_multi: one catchable object shared by NUM_HOOKS hooks (spawn, capture, pull, score or destroy)
//   Clk/reset            clock, async active-high reset; new_game is a synchronous restart
//   home_x/home_y        spawn position; DrawX/DrawY pixel being drawn
//   tail_x/tail_y/r_mode per-hook tail position and angle code; hook_back/explode per-hook events
//   cur_x/cur_y          object position; is_obj/rom_addr sprite hit and ROM address
//   catch_by             one-hot owning hook; destroyed/exploded/score_pulse/score_value status
module catch_object_multi #(
  parameter int         WIDTH     = 30,
  parameter int         LENGTH    = 30,
  parameter int         NUM_HOOKS = 2,
  parameter int         TICK_DIV  = 2000000,
  parameter logic [7:0] VALUE     = 8'd20,
  parameter logic [9:0] MAX_X     = 10'd639,
  parameter logic [9:0] MAX_Y     = 10'd479
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic [9:0]             home_x,
  input  logic [9:0]             home_y,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [10*NUM_HOOKS-1:0] tail_x,
  input  logic [10*NUM_HOOKS-1:0] tail_y,
  input  logic [4*NUM_HOOKS-1:0] r_mode,
  input  logic [NUM_HOOKS-1:0]   hook_back,
  input  logic [NUM_HOOKS-1:0]   explode,
  output logic [9:0]             cur_x,
  output logic [9:0]             cur_y,
  output logic                   is_obj,
  output logic [18:0]            rom_addr,
  output logic [NUM_HOOKS-1:0]   catch_by,
  output logic                   destroyed,
  output logic                   exploded,
  output logic                   score_pulse,
  output logic [7:0]             score_value
);
  localparam int TW = $clog2(TICK_DIV + 1);
  typedef enum logic [1:0] {IDLE, PULL, GONE} state_t;
  state_t state_q, state_d;
  logic [10*NUM_HOOKS-1:0] tail_x_q, tail_y_q;
  logic [9:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d, step_q, step_d, off_x, off_y;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] dir_q, dir_d, hit_dir;
  logic [NUM_HOOKS-1:0] catch_by_q, catch_by_d, hit, first_hit;
  logic destroyed_q, destroyed_d, exploded_q, exploded_d, score_pulse_q, score_pulse_d;
  logic own_back, own_boom, tick_end;
  logic [7:0] vec;
  logic signed [17:0] dx, dy, sum_x, sum_y;

  function automatic logic [7:0] dir_vec(input logic [3:0] code);
    case (code)
      4'd0:    return {4'(6), 4'(0)};
      4'd1:    return {4'(6), 4'(-1)};
      4'd2:    return {4'(5), 4'(-2)};
      4'd3:    return {4'(4), 4'(-3)};
      4'd4:    return {4'(2), 4'(-4)};
      4'd5:    return {4'(0), 4'(-6)};
      4'd6:    return {4'(-2), 4'(-4)};
      4'd7:    return {4'(-4), 4'(-3)};
      4'd8:    return {4'(-5), 4'(-2)};
      4'd9:    return {4'(-6), 4'(-1)};
      4'd10:   return {4'(-6), 4'(0)};
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [9:0] clamp(input logic signed [17:0] v, input logic [9:0] lim);
    return v[17] ? 10'd0 : (v > $signed({8'b0, lim})) ? lim : v[9:0];
  endfunction

  function automatic logic in_box(input logic [9:0] px, py, bx, by);
    return {1'b0, px} >= {1'b0, bx} && {1'b0, px} <= {1'b0, bx} + 11'(LENGTH - 1) &&
           {1'b0, py} >= {1'b0, by} && {1'b0, py} <= {1'b0, by} + 11'(WIDTH - 1);
  endfunction

  // In IDLE the object follows home combinationally so the async reset value equals home.
  assign cur_x       = state_q == IDLE ? home_x : cur_x_q;
  assign cur_y       = state_q == IDLE ? home_y : cur_y_q;
  assign catch_by    = catch_by_q;
  assign destroyed   = destroyed_q;
  assign exploded    = exploded_q;
  assign score_pulse = score_pulse_q;
  assign score_value = score_pulse_q ? VALUE : 8'd0;
  assign is_obj      = !destroyed_q && in_box(DrawX, DrawY, cur_x, cur_y);
  assign off_x       = DrawX - cur_x;
  assign off_y       = DrawY - cur_y;
  assign rom_addr    = 19'(off_y) * 19'(LENGTH) + 19'(off_x);
  assign own_back    = |(hook_back & catch_by_q);
  assign own_boom    = |(explode & catch_by_q);
  assign tick_end    = tick_q == TW'(TICK_DIV - 1);

  always_comb begin
    hit = '0;
    hit_dir = 4'd0;
    for (int i = 0; i < NUM_HOOKS; i++)
      hit[i] = in_box(tail_x_q[10*i +: 10], tail_y_q[10*i +: 10], cur_x, cur_y);
    for (int i = NUM_HOOKS - 1; i >= 0; i--)
      if (hit[i]) hit_dir = r_mode[4*i +: 4];
    first_hit = hit & (~hit + NUM_HOOKS'(1));
  end

  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    catch_by_d = catch_by_q;
    step_d = step_q;
    tick_d = tick_q;
    destroyed_d = destroyed_q;
    exploded_d = exploded_q;
    score_pulse_d = 1'b0;
    case (state_q)
      IDLE: if (|hit) begin
        state_d = PULL;
        dir_d = hit_dir;
        catch_by_d = first_hit;
        step_d = '0;
        tick_d = '0;
      end
      PULL: begin
        tick_d = tick_end ? '0 : tick_q + TW'(1);
        step_d = tick_end && step_q != 10'd1023 ? step_q + 10'd1 : step_q;
        if (own_boom || own_back) begin
          state_d = GONE;
          catch_by_d = '0;
          destroyed_d = 1'b1;
          exploded_d = own_boom;
          score_pulse_d = !own_boom;
        end
      end
      default: ;
    endcase
    if (new_game) begin
      state_d = IDLE;
      dir_d = 4'd0;
      catch_by_d = '0;
      step_d = '0;
      tick_d = '0;
      destroyed_d = 1'b0;
      exploded_d = 1'b0;
      score_pulse_d = 1'b0;
    end
    vec = dir_vec(dir_d);
    dx = {{14{vec[7]}}, vec[7:4]};
    dy = {{14{vec[3]}}, vec[3:0]};
    // Wider than 12 bits so a saturated step count cannot wrap before clamping.
    sum_x = $signed({8'b0, home_x}) + $signed({8'b0, step_d}) * dx;
    sum_y = $signed({8'b0, home_y}) + $signed({8'b0, step_d}) * dy;
    cur_x_d = state_d == PULL ? clamp(sum_x, MAX_X) : state_d == GONE ? 10'd0 : home_x;
    cur_y_d = state_d == PULL ? clamp(sum_y, MAX_Y) : state_d == GONE ? 10'd0 : home_y;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tail_x_q <= '0;
      tail_y_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      step_q <= '0;
      tick_q <= '0;
      dir_q <= '0;
      catch_by_q <= '0;
      destroyed_q <= 1'b0;
      exploded_q <= 1'b0;
      score_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_x_q <= tail_x;
      tail_y_q <= tail_y;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      step_q <= step_d;
      tick_q <= tick_d;
      dir_q <= dir_d;
      catch_by_q <= catch_by_d;
      destroyed_q <= destroyed_d;
      exploded_q <= exploded_d;
      score_pulse_q <= score_pulse_d;
    end
  end
endmodule

// File: tb/tb_catch_object_multi.sv
// tb_catch_object_multi: directed and randomized checks of catch_object_multi against a behavioural model
module tb_catch_object_multi;
  localparam int NH = 2, TD = 4;
  logic Clk = 1'b0, reset = 1'b1, new_game = 1'b0;
  logic [9:0] home_x = 10'd100, home_y = 10'd200, DrawX = '0, DrawY = '0;
  logic [10*NH-1:0] tail_x = '0, tail_y = '0;
  logic [4*NH-1:0] r_mode = '0;
  logic [NH-1:0] hook_back = '0, explode = '0;
  logic [9:0] cur_x, cur_y;
  logic is_obj;
  logic [18:0] rom_addr;
  logic [NH-1:0] catch_by;
  logic destroyed, exploded, score_pulse;
  logic [7:0] score_value;
  int passed = 0, total = 0;

  catch_object_multi #(.WIDTH(30), .LENGTH(30), .NUM_HOOKS(NH), .TICK_DIV(TD)) dut (
    .Clk(Clk), .reset(reset), .new_game(new_game), .home_x(home_x), .home_y(home_y),
    .DrawX(DrawX), .DrawY(DrawY), .tail_x(tail_x), .tail_y(tail_y), .r_mode(r_mode),
    .hook_back(hook_back), .explode(explode), .cur_x(cur_x), .cur_y(cur_y), .is_obj(is_obj),
    .rom_addr(rom_addr), .catch_by(catch_by), .destroyed(destroyed), .exploded(exploded),
    .score_pulse(score_pulse), .score_value(score_value));

  always #5 Clk = ~Clk;

  // Behavioural model: who owns the object, how long it has been pulled, and how it ended.
  int m_owner, m_cyc, m_dir;
  bit m_gone, m_expl, m_pulse;
  int ptx[NH], pty[NH];
  int vx[16] = '{6, 6, 5, 4, 2, 0, -2, -4, -5, -6, -6, 0, 0, 0, 0, 0};
  int vy[16] = '{0, -1, -2, -3, -4, -6, -4, -3, -2, -1, 0, 0, 0, 0, 0, 0};

  function automatic int clampi(int v, int lim);
    return v < 0 ? 0 : (v > lim ? lim : v);
  endfunction

  function int steps();
    return m_cyc / TD > 1023 ? 1023 : m_cyc / TD;
  endfunction

  function int ecx();
    if (m_gone) return 0;
    if (m_owner < 0) return int'(home_x);
    return clampi(int'(home_x) + steps() * vx[m_dir], 639);
  endfunction

  function int ecy();
    if (m_gone) return 0;
    if (m_owner < 0) return int'(home_y);
    return clampi(int'(home_y) + steps() * vy[m_dir], 479);
  endfunction

  function logic [NH-1:0] ecatch();
    return (m_owner >= 0 && !m_gone) ? NH'(1 << m_owner) : '0;
  endfunction

  task automatic model_reset(input bit clear_tails);
    m_owner = -1; m_cyc = 0; m_dir = 0; m_gone = 0; m_expl = 0; m_pulse = 0;
    if (clear_tails) for (int i = 0; i < NH; i++) begin ptx[i] = 0; pty[i] = 0; end
  endtask

  task automatic model_edge();
    int hx, hy;
    hx = ecx(); hy = ecy();
    m_pulse = 0;
    if (new_game) model_reset(0);
    else if (!m_gone && m_owner < 0) begin
      for (int i = 0; i < NH; i++)
        if (m_owner < 0 && ptx[i] >= hx && ptx[i] <= hx + 29 && pty[i] >= hy && pty[i] <= hy + 29) begin
          m_owner = i; m_dir = int'(r_mode[4*i +: 4]); m_cyc = 0;
        end
    end else if (!m_gone) begin
      if (explode[m_owner]) begin m_gone = 1; m_expl = 1; end
      else if (hook_back[m_owner]) begin m_gone = 1; m_pulse = 1; end
      else m_cyc++;
    end
    for (int i = 0; i < NH; i++) begin ptx[i] = int'(tail_x[10*i +: 10]); pty[i] = int'(tail_y[10*i +: 10]); end
  endtask

  task automatic cycle();
    if (reset) model_reset(1); else model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_tail(input int i, input int x, input int y);
    tail_x[10*i +: 10] = 10'(x);
    tail_y[10*i +: 10] = 10'(y);
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset(1);
    #2;
    total++;
    if ({cur_x, cur_y} !== {10'd100, 10'd200}) begin
      $display("FAIL reset_cur: got (%0d,%0d) want (100,200)", cur_x, cur_y);
    end else passed++;
    total++;
    if ({catch_by, destroyed, exploded, score_pulse, score_value} !== '0) begin
      $display("FAIL reset_status: got catch_by=%b d=%b e=%b p=%b v=%0d want all 0",
               catch_by, destroyed, exploded, score_pulse, score_value);
    end else passed++;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_spawn_draw();
    set_tail(0, 0, 0); set_tail(1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle();
      total++;
      if ({cur_x, cur_y, catch_by} !== {10'd100, 10'd200, 2'b00}) begin
        $display("FAIL spawn_hold: got (%0d,%0d) catch_by=%b want (100,200) 00", cur_x, cur_y, catch_by);
      end else passed++;
    end
    DrawX = 10'd100; DrawY = 10'd200; #1;
    total++;
    if ({is_obj, rom_addr} !== {1'b1, 19'd0}) begin
      $display("FAIL draw_corner: got is_obj=%b rom=%0d want 1 0", is_obj, rom_addr);
    end else passed++;
    DrawX = 10'd129; DrawY = 10'd229; #1;
    total++;
    if ({is_obj, rom_addr} !== {1'b1, 19'd899}) begin
      $display("FAIL draw_far_corner: got is_obj=%b rom=%0d want 1 899", is_obj, rom_addr);
    end else passed++;
    DrawX = 10'd130; DrawY = 10'd200; #1;
    total++;
    if (is_obj !== 1'b0) begin
      $display("FAIL draw_outside: got is_obj=%b want 0", is_obj);
    end else passed++;
  endtask

  task automatic test_single_catch();
    set_tail(0, 110, 210); set_tail(1, 1023, 1023); r_mode = 8'h05;
    cycle();
    total++;
    if (catch_by !== 2'b00) begin
      $display("FAIL catch_latency: got catch_by=%b want 00 after one edge", catch_by);
    end else passed++;
    cycle();
    total++;
    if (catch_by !== 2'b01) begin
      $display("FAIL catch_owner: got catch_by=%b want 01", catch_by);
    end else passed++;
    set_tail(0, 1023, 1023);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      total++;
      if ({cur_x, cur_y} !== {10'(ecx()), 10'(ecy())}) begin
        $display("FAIL pull_step: cycle %0d got (%0d,%0d) want (%0d,%0d)", k, cur_x, cur_y, ecx(), ecy());
      end else passed++;
    end
    total++;
    if ({cur_x, cur_y} !== {10'd100, 10'd182}) begin
      $display("FAIL pull_3steps: got (%0d,%0d) want (100,182)", cur_x, cur_y);
    end else passed++;
    hook_back = 2'b01;
    cycle();
    hook_back = 2'b00;
    total++;
    if ({score_pulse, score_value, destroyed, exploded, cur_x, cur_y, catch_by} !==
        {1'b1, 8'd20, 1'b1, 1'b0, 10'd0, 10'd0, 2'b00}) begin
      $display("FAIL score_edge: got p=%b v=%0d d=%b e=%b cur=(%0d,%0d) cb=%b want 1 20 1 0 (0,0) 00",
               score_pulse, score_value, destroyed, exploded, cur_x, cur_y, catch_by);
    end else passed++;
    cycle();
    DrawX = 10'd0; DrawY = 10'd0; #1;
    total++;
    if ({score_pulse, score_value, destroyed, is_obj} !== {1'b0, 8'd0, 1'b1, 1'b0}) begin
      $display("FAIL score_once: got p=%b v=%0d d=%b is_obj=%b want 0 0 1 0",
               score_pulse, score_value, destroyed, is_obj);
    end else passed++;
  endtask

  task automatic test_new_game();
    set_tail(0, 1023, 1023); set_tail(1, 1023, 1023);
    home_x = 10'd200; home_y = 10'd100;
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
    total++;
    if ({cur_x, cur_y, destroyed, exploded, catch_by} !== {10'd200, 10'd100, 1'b0, 1'b0, 2'b00}) begin
      $display("FAIL new_game: got cur=(%0d,%0d) d=%b e=%b cb=%b want (200,100) 0 0 00",
               cur_x, cur_y, destroyed, exploded, catch_by);
    end else passed++;
  endtask

  task automatic test_simultaneous();
    set_tail(0, 205, 105); set_tail(1, 220, 120); r_mode = {4'd3, 4'd0};
    cycle(); cycle();
    total++;
    if (catch_by !== 2'b01) begin
      $display("FAIL simul_owner: got catch_by=%b want 01", catch_by);
    end else passed++;
    set_tail(0, 1023, 1023); set_tail(1, 1023, 1023);
    hook_back = 2'b10; explode = 2'b10;
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++;
      if ({catch_by, destroyed, exploded, score_pulse, cur_x, cur_y} !==
          {2'b01, 1'b0, 1'b0, 1'b0, 10'(ecx()), 10'(ecy())}) begin
        $display("FAIL simul_ignore: got cb=%b d=%b e=%b p=%b cur=(%0d,%0d) want 01 0 0 0 (%0d,%0d)",
                 catch_by, destroyed, exploded, score_pulse, cur_x, cur_y, ecx(), ecy());
      end else passed++;
    end
    hook_back = 2'b00; explode = 2'b00;
  endtask

  task automatic test_explode_precedence();
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
    set_tail(1, 210, 110); r_mode = {4'd7, 4'd0};
    cycle(); cycle();
    total++;
    if (catch_by !== 2'b10) begin
      $display("FAIL boom_owner: got catch_by=%b want 10", catch_by);
    end else passed++;
    set_tail(1, 1023, 1023);
    repeat (5) cycle();
    explode = 2'b10; hook_back = 2'b10;
    cycle();
    explode = 2'b00; hook_back = 2'b00;
    total++;
    if ({exploded, destroyed, score_pulse, score_value} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      $display("FAIL boom_wins: got e=%b d=%b p=%b v=%0d want 1 1 0 0", exploded, destroyed, score_pulse, score_value);
    end else passed++;
    cycle();
    total++;
    if ({exploded, destroyed, score_pulse} !== 3'b110) begin
      $display("FAIL boom_hold: got e=%b d=%b p=%b want 1 1 0", exploded, destroyed, score_pulse);
    end else passed++;
  endtask

  task automatic test_clamp();
    home_x = 10'd3; home_y = 10'd3;
    new_game = 1'b1;
    cycle();
    new_game = 1'b0;
    set_tail(0, 10, 10); r_mode = {4'd0, 4'd10};
    cycle(); cycle();
    set_tail(0, 1023, 1023);
    repeat (20) cycle();
    total++;
    if ({cur_x, cur_y, catch_by} !== {10'd0, 10'd3, 2'b01}) begin
      $display("FAIL clamp_left: got (%0d,%0d) cb=%b want (0,3) 01", cur_x, cur_y, catch_by);
    end else passed++;
  endtask

  task automatic test_reset_mid_pull();
    #3;
    reset = 1'b1; model_reset(1);
    #1;
    total++;
    if ({cur_x, cur_y, catch_by, destroyed, exploded, score_pulse, score_value} !=
        {10'd3, 10'd3, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL async_reset: got cur=(%0d,%0d) cb=%b d=%b e=%b p=%b v=%0d want (3,3) 00 0 0 0 0",
               cur_x, cur_y, catch_by, destroyed, exploded, score_pulse, score_value);
    end else passed++;
    cycle();
    reset = 1'b0;
    cycle();
    total++;
    if ({score_pulse, catch_by, cur_x, cur_y} !== {1'b0, 2'b00, 10'd3, 10'd3}) begin
      $display("FAIL reset_after: got p=%b cb=%b cur=(%0d,%0d) want 0 00 (3,3)", score_pulse, catch_by, cur_x, cur_y);
    end else passed++;
  endtask

  task automatic test_random();
    int ex, ey, obj;
    for (int r = 0; r < 12; r++) begin
      home_x = 10'($urandom_range(0, 639)); home_y = 10'($urandom_range(0, 479));
      set_tail(0, 1023, 1023); set_tail(1, 1023, 1023); hook_back = '0; explode = '0;
      new_game = 1'b1;
      cycle();
      new_game = 1'b0;
      for (int k = 0; k < 40; k++) begin
        for (int i = 0; i < NH; i++)
          if ($urandom_range(0, 3) == 0) set_tail(i, ecx() + $urandom_range(0, 29), ecy() + $urandom_range(0, 29));
          else set_tail(i, 1023, 1023);
        r_mode = 8'($urandom);
        hook_back = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
        explode = ($urandom_range(0, 11) == 0) ? 2'($urandom) : 2'b00;
        new_game = ($urandom_range(0, 29) == 0);
        cycle();
        DrawX = 10'(ecx() + $urandom_range(0, 34) - 2); DrawY = 10'(ecy() + $urandom_range(0, 34) - 2);
        #1;
        ex = ecx(); ey = ecy();
        obj = (!m_gone && int'(DrawX) >= ex && int'(DrawX) <= ex + 29 && int'(DrawY) >= ey && int'(DrawY) <= ey + 29);
        total++;
        if ({cur_x, cur_y, catch_by, destroyed, exploded, score_pulse, score_value, is_obj} !==
            {10'(ex), 10'(ey), ecatch(), m_gone, m_expl, m_pulse, m_pulse ? 8'd20 : 8'd0, obj[0]} ||
            (obj != 0 && rom_addr !== 19'((int'(DrawY) - ey) * 30 + (int'(DrawX) - ex)))) begin
          $display("FAIL random r%0d k%0d: got cur=(%0d,%0d) cb=%b d=%b e=%b p=%b v=%0d obj=%b rom=%0d want cur=(%0d,%0d) cb=%b d=%b e=%b p=%b obj=%0d",
                   r, k, cur_x, cur_y, catch_by, destroyed, exploded, score_pulse, score_value, is_obj, rom_addr,
                   ex, ey, ecatch(), m_gone, m_expl, m_pulse, obj);
        end else passed++;
      end
      new_game = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_spawn_draw();
    test_single_catch();
    test_new_game();
    test_simultaneous();
    test_explode_precedence();
    test_clamp();
    test_reset_mid_pull();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
